// File: rtl/hero_input_pkg.sv
// Shared game definitions: direction codes, attack code, button indices and
// the direction priority selector used by the hero input stage.
package hero_input_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    localparam logic [2:0] ATTACK_NONE = 3'b100;

    localparam int unsigned NUM_BTN   = 5;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_POWER = 4;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_set_t;

    // Simultaneous rises resolve up > down > left > right; no rise keeps cur.
    function automatic dir_t dir_select(input dir_set_t rise, input dir_t cur);
        dir_t sel;
        sel = cur;
        if (rise.up)
            sel = DIR_UP;
        else if (rise.down)
            sel = DIR_DOWN;
        else if (rise.left)
            sel = DIR_LEFT;
        else if (rise.right)
            sel = DIR_RIGHT;
        return sel;
    endfunction

endpackage

// File: rtl/hero_input_button_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level
// and a strobe marking the edge on which the level rises.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_s;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // rise is asserted in the cycle before level goes high so that consumers
    // can register the event on the same edge that updates level.
    assign accept = (sync_s != level) && (cnt == CNT_LAST);
    assign rise   = accept && sync_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= btn;
            sync_s    <= sync_meta;
            if (sync_s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hero_input.sv
// Game input stage: debounces the five board buttons, latches hero facing on
// direction presses and emits a one-cycle power toggle pulse.
module hero_input
    import hero_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_power,
    output logic [1:0] state_hero,
    output logic       pressing,
    output logic       pressed,
    output logic       power
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    dir_set_t           dir_rise;
    dir_t               hero_q;

    assign raw = {btn_power, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (raw[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    assign dir_rise = '{
        up:    rise[BTN_UP],
        down:  rise[BTN_DOWN],
        left:  rise[BTN_LEFT],
        right: rise[BTN_RIGHT]
    };

    // Debounced levels are registered, so this OR cannot glitch.
    assign pressing = level[BTN_UP] | level[BTN_DOWN] | level[BTN_LEFT] | level[BTN_RIGHT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hero_q  <= DIR_UP;
            pressed <= 1'b0;
            power   <= 1'b0;
        end else begin
            hero_q  <= dir_select(dir_rise, hero_q);
            pressed <= pressing;
            power   <= rise[BTN_POWER];
        end
    end

    assign state_hero = hero_q;

endmodule

// File: tb/tb_hero_input.sv
// Directed and randomized checks of hero_input against a sample-history
// reference model, DEBOUNCE_CYCLES = 4.
module tb_hero_input;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;   // 0 up, 1 down, 2 left, 3 right, 4 power
    logic [1:0] state_hero;
    logic       pressing;
    logic       pressed;
    logic       power;

    int n_cmp = 0;
    int n_err = 0;
    int n_prise = 0;
    int n_pwr = 0;
    int pwr_streak = 0;
    int pwr_max = 0;

    hero_input #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn[0]),
        .btn_down  (btn[1]),
        .btn_left  (btn[2]),
        .btn_right (btn[3]),
        .btn_power (btn[4]),
        .state_hero(state_hero),
        .pressing  (pressing),
        .pressed   (pressed),
        .power     (power)
    );

    always #5 clk = ~clk;

    // Reference model: a button's accepted level becomes the synchronised value
    // once that value has been seen for N consecutive samples.
    bit          m_s1[5];
    bit          m_s2[5];
    bit          m_d[5];
    bit          m_last[5];
    int unsigned m_run[5];
    logic [1:0]  m_hero;
    bit          m_pressed;
    bit          m_power;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_d[i] = 0; m_last[i] = 0; m_run[i] = 0;
            end
            m_hero = 2'b01;
            m_pressed = 0;
            m_power = 0;
        end else begin
            bit old_or;
            bit rose[5];
            old_or = m_d[0] | m_d[1] | m_d[2] | m_d[3];
            for (int i = 0; i < 5; i++) begin
                rose[i] = 0;
                if (m_s2[i] == m_last[i]) m_run[i]++;
                else m_run[i] = 1;
                m_last[i] = m_s2[i];
                if (m_s2[i] != m_d[i] && m_run[i] >= N) begin
                    m_d[i] = m_s2[i];
                    rose[i] = m_s2[i];
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = btn[i];
            end
            if (rose[0]) m_hero = 2'b01;
            else if (rose[1]) m_hero = 2'b00;
            else if (rose[2]) m_hero = 2'b11;
            else if (rose[3]) m_hero = 2'b10;
            m_pressed = old_or;
            m_power = rose[4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        chk("model_hero", 32'(state_hero), 32'(m_hero));
        chk("model_pressing", 32'(pressing), 32'(m_d[0] | m_d[1] | m_d[2] | m_d[3]));
        chk("model_pressed", 32'(pressed), 32'(m_pressed));
        chk("model_power", 32'(power), 32'(m_power));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        check_model();
        if (pressing && !pressed) n_prise++;
        if (power) begin
            n_pwr++;
            pwr_streak++;
            if (pwr_streak > pwr_max) pwr_max = pwr_streak;
        end else begin
            pwr_streak = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hero"}, 32'(state_hero), 32'h1);
        chk({tag, "_pressing"}, 32'(pressing), 32'h0);
        chk({tag, "_pressed"}, 32'(pressed), 32'h0);
        chk({tag, "_power"}, 32'(power), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        idle(3);

        // Reset in the middle of a left debounce, left kept held
        btn[2] = 1'b1;
        idle(4);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("midrst_wait_pressing", 32'(pressing), 32'h0);
        end
        cyc();
        chk("midrst_accept_pressing", 32'(pressing), 32'h1);
        chk("midrst_accept_hero", 32'(state_hero), 32'h3);
        btn[2] = 1'b0;
        idle(10);

        // Clean down press: accepted on the sixth edge after the change
        n_prise = 0;
        btn[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("down_wait_pressing", 32'(pressing), 32'h0);
        end
        cyc();
        chk("down_hero", 32'(state_hero), 32'h0);
        chk("down_pressing", 32'(pressing), 32'h1);
        chk("down_pressed_lag", 32'(pressed), 32'h0);
        cyc();
        chk("down_pressed", 32'(pressed), 32'h1);
        idle(12);
        chk("down_rise_count", 32'(n_prise), 32'h1);
        btn[1] = 1'b0;
        idle(10);

        // Right bouncing every 2 cycles never gets through
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) btn[3] = ~btn[3];
            cyc();
            chk("bounce_pressing", 32'(pressing), 32'h0);
            chk("bounce_hero", 32'(state_hero), 32'h0);
        end
        btn[3] = 1'b0;
        idle(10);

        // Up and left together: up wins; releasing up keeps facing and pressing
        btn[0] = 1'b1;
        btn[2] = 1'b1;
        idle(8);
        chk("upleft_hero", 32'(state_hero), 32'h1);
        btn[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("upleft_rel_hero", 32'(state_hero), 32'h1);
            chk("upleft_rel_pressing", 32'(pressing), 32'h1);
        end
        btn[2] = 1'b0;
        idle(10);

        // Hold left then add right: facing follows, one pressing rise only
        n_prise = 0;
        btn[2] = 1'b1;
        idle(8);
        chk("lr_left_hero", 32'(state_hero), 32'h3);
        btn[3] = 1'b1;
        idle(8);
        chk("lr_right_hero", 32'(state_hero), 32'h2);
        chk("lr_rise_count", 32'(n_prise), 32'h1);
        btn[2] = 1'b0;
        btn[3] = 1'b0;
        idle(10);

        // Power held long: one single-cycle pulse; re-press gives another
        n_pwr = 0;
        pwr_max = 0;
        btn[4] = 1'b1;
        idle(100);
        chk("pwr_hold_count", 32'(n_pwr), 32'h1);
        btn[4] = 1'b0;
        idle(12);
        chk("pwr_release_count", 32'(n_pwr), 32'h1);
        btn[4] = 1'b1;
        idle(20);
        chk("pwr_repress_count", 32'(n_pwr), 32'h2);
        chk("pwr_width", 32'(pwr_max), 32'h1);
        btn[4] = 1'b0;
        idle(10);

        // Random button activity with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            btn = 5'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            idle(int'($urandom_range(1, 8)));
        end
        btn = '0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
